flip_engine: RTL

Parametrised, multi-mode successor to the 8-bit bit-flip unit on the RS232 path of the gobang design. It accepts a DATA_W-bit word plus a mode, permutes it STEP bits per cycle, and reports completion with a one-cycle pulse. Supported permutations are full-word bit reversal, per-byte bit reversal, byte swap and pass-through. It sits between the UART byte/word assembler and the board-logic consumer, and supports abort and back-to-back jobs.

---
 rtl/flip_pkg.sv | 32 +++
 rtl/flip_engine.sv | 100 ++++++++++
 2 files changed

// File: rtl/flip_pkg.sv
// flip_pkg: shared types and the index map for flip_engine.
// perm_idx gives the destination bit for a source bit under each mode.
package flip_pkg;

   typedef enum logic [1:0] {
      FLIP_PASS,
      FLIP_REV,
      FLIP_BYTE_REV,
      FLIP_SWAP
   } flip_mode_e;

   typedef enum logic [1:0] {
      S_IDLE,
      S_BUSY,
      S_DONE
   } state_e;

   function automatic int perm_idx(
      input flip_mode_e mode,
      input int         idx,
      input int         data_w
   );
      case (mode)
         FLIP_PASS:     return idx;
         FLIP_REV:      return data_w - 1 - idx;
         FLIP_BYTE_REV: return 8 * (idx / 8) + 7 - idx % 8;
         FLIP_SWAP:     return 8 * (data_w / 8 - 1 - idx / 8) + idx % 8;
         default:       return idx;
      endcase
   endfunction

endpackage

// File: rtl/flip_engine.sv
// flip_engine: multi-cycle bit permutation unit, STEP bits per cycle.
// Word captured on accept, result published with a one-cycle done pulse.
import flip_pkg::*;

module flip_engine #(
   parameter int DATA_W = 8,
   parameter int STEP   = 1
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_start,
   input  logic [1:0]        i_mode,
   input  logic [DATA_W-1:0] i_data,
   input  logic              i_abort,
   output logic [DATA_W-1:0] o_data,
   output logic              o_finished,
   output logic              o_busy
);

   localparam int N  = DATA_W / STEP;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam int IW = $clog2(DATA_W);

   if (DATA_W % 8 != 0) begin : g_bad_width
      $error("flip_engine: DATA_W must be a multiple of 8");
   end
   if (DATA_W % STEP != 0) begin : g_bad_step
      $error("flip_engine: STEP must divide DATA_W");
   end

   state_e            state;
   flip_mode_e        mode;
   logic [DATA_W-1:0] src_word;
   logic [DATA_W-1:0] work;
   logic [DATA_W-1:0] nxt;
   logic [CW-1:0]     cnt;
   logic              last;
   logic [IW-1:0]     src [STEP];
   logic [IW-1:0]     dst [STEP];

   assign last = (cnt == CW'(N - 1));

   for (genvar j = 0; j < STEP; j++) begin : g_idx
      assign src[j] = IW'(int'(cnt) * STEP + j);
      assign dst[j] = IW'(perm_idx(mode, int'(cnt) * STEP + j, DATA_W));
   end

   // merge the current chunk into the partially built word
   always_comb begin
      nxt = work;
      for (int j = 0; j < STEP; j++) begin
         nxt[dst[j]] = src_word[src[j]];
      end
   end

   // job sequencing: accept, chunk walk, publish, abort
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state    <= S_IDLE;
         mode     <= FLIP_PASS;
         src_word <= '0;
         work     <= '0;
         cnt      <= '0;
         o_data   <= '0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (i_start) begin
                  src_word <= i_data;
                  mode     <= flip_mode_e'(i_mode);
                  work     <= '0;
                  cnt      <= '0;
                  state    <= S_BUSY;
               end
            end
            S_BUSY: begin
               if (i_abort) begin
                  work  <= '0;
                  cnt   <= '0;
                  state <= S_IDLE;
               end else if (last) begin
                  work   <= nxt;
                  cnt    <= '0;
                  o_data <= nxt;
                  state  <= S_DONE;
               end else begin
                  work <= nxt;
                  cnt  <= cnt + 1'b1;
               end
            end
            S_DONE: state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   assign o_busy     = (state != S_IDLE);
   assign o_finished = (state == S_DONE);

endmodule
